// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: clock inhibit, request-to-send, 11-bit frame, device ack.
// Build option: define PS2_TX_RETRY_EN to retry a nacked or timed-out frame once with the same byte.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 2838,
  parameter int TIMEOUT_CYCLES = 425625
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_i,
  input  logic       ps2_dat_i,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  output logic       tx_busy,
  output logic       done,
  output logic [1:0] status
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_REQ,
    S_SHIFT,
    S_ACK,
    S_RECOVER
  } state_t;

  localparam logic [19:0] INH_LAST  = 20'(INHIBIT_CYCLES - 1);
  localparam logic [19:0] TMO_LIMIT = 20'(TIMEOUT_CYCLES);
  localparam logic [1:0]  ST_ACK    = 2'b00;
  localparam logic [1:0]  ST_NACK   = 2'b01;
  localparam logic [1:0]  ST_TMO    = 2'b10;

  state_t      r_state, w_next_state;
  logic [19:0] r_cnt, w_next_cnt, w_cnt_inc;
  logic [9:0]  r_frame, w_next_frame;
  logic [3:0]  r_bit, w_next_bit;
  logic        r_dat_oe, w_next_dat_oe;
  logic        r_done, w_next_done;
  logic [1:0]  r_status, w_next_status;
  logic [2:0]  r_clk_sync;
  logic [1:0]  r_dat_sync;
  logic        w_fall, w_clk_s, w_dat_s, w_accept, w_tmo, w_retry;

`ifdef PS2_TX_RETRY_EN
  logic        r_retried, w_next_retried;
  assign w_retry = ~r_retried;
`else
  assign w_retry = 1'b0;
`endif

  // Bit 0/1 are the synchronizer, bit 2 is the previous synced level for edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_clk_sync <= 3'b111;
      r_dat_sync <= 2'b11;
    end else begin
      r_clk_sync <= {r_clk_sync[1:0], ps2_clk_i};
      r_dat_sync <= {r_dat_sync[0], ps2_dat_i};
    end
  end

  assign w_clk_s  = r_clk_sync[1];
  assign w_dat_s  = r_dat_sync[1];
  assign w_fall   = (r_clk_sync[2:1] == 2'b10);
  assign w_accept = tx_valid & tx_ready;
  assign w_tmo    = (r_cnt == TMO_LIMIT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_frame  <= '0;
      r_bit    <= '0;
      r_dat_oe <= 1'b0;
      r_done   <= 1'b0;
      r_status <= 2'b00;
    end else begin
      r_state  <= w_next_state;
      r_cnt    <= w_next_cnt;
      r_frame  <= w_next_frame;
      r_bit    <= w_next_bit;
      r_dat_oe <= w_next_dat_oe;
      r_done   <= w_next_done;
      r_status <= w_next_status;
    end
  end

`ifdef PS2_TX_RETRY_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_retried <= 1'b0;
    else       r_retried <= w_next_retried;
  end
`endif

  always_comb begin
    w_next_state  = r_state;
    w_next_cnt    = r_cnt;
    w_next_frame  = r_frame;
    w_next_bit    = r_bit;
    w_next_dat_oe = r_dat_oe;
    w_next_done   = 1'b0;
    w_next_status = r_status;
`ifdef PS2_TX_RETRY_EN
    w_next_retried = r_retried;
`endif
    // One counter serves the inhibit hold and, from REQ onward, the saturating timeout.
    w_cnt_inc = (r_cnt == 20'hFFFFF) ? r_cnt : r_cnt + 20'd1;

    case (r_state)
      S_IDLE: begin
        w_next_dat_oe = 1'b0;
        if (w_accept) begin
          w_next_frame = {1'b1, ~^tx_data, tx_data};
          w_next_cnt   = '0;
          w_next_bit   = '0;
          w_next_state = S_INHIBIT;
`ifdef PS2_TX_RETRY_EN
          w_next_retried = 1'b0;
`endif
        end
      end

      S_INHIBIT: begin
        if (r_cnt == INH_LAST) begin
          w_next_cnt    = '0;
          w_next_dat_oe = 1'b1;
          w_next_state  = S_REQ;
        end else begin
          w_next_cnt = w_cnt_inc;
        end
      end

      S_REQ, S_SHIFT, S_ACK: begin
        w_next_cnt = w_cnt_inc;
        if (w_tmo) begin
          w_next_dat_oe = 1'b0;
          if (w_retry) begin
            w_next_cnt   = '0;
            w_next_state = S_INHIBIT;
`ifdef PS2_TX_RETRY_EN
            w_next_retried = 1'b1;
`endif
          end else begin
            w_next_done   = 1'b1;
            w_next_status = ST_TMO;
            w_next_state  = S_IDLE;
          end
        end else if (w_fall) begin
          if (r_state == S_REQ) begin
            w_next_dat_oe = ~r_frame[0];
            w_next_bit    = 4'd1;
            w_next_state  = S_SHIFT;
          end else if (r_state == S_SHIFT) begin
            w_next_dat_oe = ~r_frame[r_bit];
            w_next_bit    = r_bit + 4'd1;
            if (r_bit == 4'd9) w_next_state = S_ACK;
          end else if (w_dat_s && w_retry) begin
            w_next_dat_oe = 1'b0;
            w_next_cnt    = '0;
            w_next_state  = S_INHIBIT;
`ifdef PS2_TX_RETRY_EN
            w_next_retried = 1'b1;
`endif
          end else begin
            w_next_status = w_dat_s ? ST_NACK : ST_ACK;
            w_next_state  = S_RECOVER;
          end
        end
      end

      S_RECOVER: begin
        if (w_clk_s && w_dat_s) begin
          w_next_done  = 1'b1;
          w_next_state = S_IDLE;
        end
      end

      default: w_next_state = S_IDLE;
    endcase
  end

  // done is registered, so ready is held off for the done cycle itself.
  assign tx_ready   = (r_state == S_IDLE) & ~r_done;
  assign tx_busy    = ~tx_ready;
  assign ps2_clk_oe = (r_state == S_INHIBIT);
  assign ps2_dat_oe = (r_state == S_INHIBIT) ? (r_cnt == INH_LAST) : r_dat_oe;
  assign done       = r_done;
  assign status     = r_status;

endmodule
